// File: rtl/ac_stress_cycle_cnt.sv
// AC stress cycle counter: counts divider rising edges under a run/pause/done FSM
// against a programmable target, with a toggle-handshake snapshot port for readout.
module ac_stress_cycle_cnt #(
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             AC_STRESS_CLK,
  input  logic             RESETB,
  input  logic             FREQ_DIV_OUT,
  input  logic             STRESS_EN,
  input  logic             CLR,
  input  logic [CNT_W-1:0] TARGET,
  input  logic             SNAP_REQ,
  output logic [CNT_W-1:0] STRESS_CNT,
  output logic             STRESS_ACTIVE,
  output logic             STRESS_DONE,
  output logic             CNT_OVF,
  output logic [CNT_W-1:0] SNAP_CNT,
  output logic             SNAP_ACK
);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] en_sync_q, clr_sync_q, req_sync_q;
  logic                   clr_d_q, clr_p_q, div_d_q;
  logic                   en_s, clr_s, req_s;
  logic                   div_edge, cnt_sat, hit_target;
  logic [CNT_W-1:0]       cnt_inc;

  assign en_s  = en_sync_q[SYNC_STAGES-1];
  assign clr_s = clr_sync_q[SYNC_STAGES-1];
  assign req_s = req_sync_q[SYNC_STAGES-1];

  assign div_edge   = FREQ_DIV_OUT & ~div_d_q;
  assign cnt_sat    = &STRESS_CNT;
  assign cnt_inc    = STRESS_CNT + CNT_W'(1);
  assign hit_target = (TARGET != '0) && (cnt_inc == TARGET);

  // Synchronizers, divider edge detect and a registered clear pulse.
  always_ff @(posedge AC_STRESS_CLK or negedge RESETB) begin
    if (!RESETB) begin
      en_sync_q  <= '0;
      clr_sync_q <= '0;
      req_sync_q <= '0;
      clr_d_q    <= 1'b0;
      clr_p_q    <= 1'b0;
      div_d_q    <= 1'b0;
    end else begin
      en_sync_q  <= {en_sync_q[SYNC_STAGES-2:0], STRESS_EN};
      clr_sync_q <= {clr_sync_q[SYNC_STAGES-2:0], CLR};
      req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], SNAP_REQ};
      clr_d_q    <= clr_s;
      clr_p_q    <= clr_s & ~clr_d_q;
      div_d_q    <= FREQ_DIV_OUT;
    end
  end

  always_ff @(posedge AC_STRESS_CLK or negedge RESETB) begin
    if (!RESETB) begin
      state_q       <= StIdle;
      STRESS_CNT    <= '0;
      STRESS_ACTIVE <= 1'b0;
      STRESS_DONE   <= 1'b0;
      CNT_OVF       <= 1'b0;
    end else if (clr_p_q) begin
      // Clear wins over any same-cycle divider edge.
      state_q       <= StIdle;
      STRESS_CNT    <= '0;
      STRESS_ACTIVE <= 1'b0;
      STRESS_DONE   <= 1'b0;
      CNT_OVF       <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (en_s) begin
            state_q       <= StRun;
            STRESS_ACTIVE <= 1'b1;
          end
        end
        StRun: begin
          if (div_edge) begin
            if (cnt_sat) begin
              CNT_OVF <= 1'b1;
            end else begin
              STRESS_CNT <= cnt_inc;
            end
          end
          if (div_edge && !cnt_sat && hit_target) begin
            state_q       <= StDone;
            STRESS_ACTIVE <= 1'b0;
            STRESS_DONE   <= 1'b1;
          end else if (!en_s) begin
            state_q       <= StPause;
            STRESS_ACTIVE <= 1'b0;
          end
        end
        StPause: begin
          if (en_s) begin
            state_q       <= StRun;
            STRESS_ACTIVE <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StDone;
        end
        default: begin
          state_q       <= StIdle;
          STRESS_ACTIVE <= 1'b0;
          STRESS_DONE   <= 1'b0;
        end
      endcase
    end
  end

  // Snapshot captures the pre-increment count; independent of clear.
  always_ff @(posedge AC_STRESS_CLK or negedge RESETB) begin
    if (!RESETB) begin
      SNAP_CNT <= '0;
      SNAP_ACK <= 1'b0;
    end else if (req_s != SNAP_ACK) begin
      SNAP_CNT <= STRESS_CNT;
      SNAP_ACK <= ~SNAP_ACK;
    end
  end

endmodule

// File: tb/tb_ac_stress_cycle_cnt.sv
// Directed bench for ac_stress_cycle_cnt: a vector table for run/pause/done plus
// hand sequences for clear, snapshot, reset and saturation corners.
module tb_ac_stress_cycle_cnt;

  localparam int unsigned W = 24;

  logic         clk = 1'b0;
  logic         resetb = 1'b0;
  logic         freq = 1'b0, en = 1'b0, clr = 1'b0, req = 1'b0;
  logic [W-1:0] target = '0;
  logic [W-1:0] cnt, snap_cnt;
  logic         active, done, ovf, ack;

  logic         freq4 = 1'b0, en4 = 1'b0, clr4 = 1'b0, req4 = 1'b0;
  logic [3:0]   target4 = '0;
  logic [3:0]   cnt4, snap_cnt4;
  logic         active4, done4, ovf4, ack4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ac_stress_cycle_cnt #(.CNT_W(W), .SYNC_STAGES(2)) u_dut (
    .AC_STRESS_CLK(clk), .RESETB(resetb), .FREQ_DIV_OUT(freq), .STRESS_EN(en),
    .CLR(clr), .TARGET(target), .SNAP_REQ(req), .STRESS_CNT(cnt),
    .STRESS_ACTIVE(active), .STRESS_DONE(done), .CNT_OVF(ovf),
    .SNAP_CNT(snap_cnt), .SNAP_ACK(ack)
  );

  ac_stress_cycle_cnt #(.CNT_W(4), .SYNC_STAGES(2)) u_dut4 (
    .AC_STRESS_CLK(clk), .RESETB(resetb), .FREQ_DIV_OUT(freq4), .STRESS_EN(en4),
    .CLR(clr4), .TARGET(target4), .SNAP_REQ(req4), .STRESS_CNT(cnt4),
    .STRESS_ACTIVE(active4), .STRESS_DONE(done4), .CNT_OVF(ovf4),
    .SNAP_CNT(snap_cnt4), .SNAP_ACK(ack4)
  );

  typedef struct {
    logic         do_clr;
    logic         en;
    logic [W-1:0] target;
    int           edges;
    logic [W-1:0] exp_cnt;
    logic         exp_active;
    logic         exp_done;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      freq = 1'b1;
      tick(1);
      freq = 1'b0;
      tick(7);
    end
  endtask

  task automatic pulse4(input int n);
    for (int i = 0; i < n; i++) begin
      freq4 = 1'b1;
      tick(1);
      freq4 = 1'b0;
      tick(7);
    end
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick(6);
    clr = 1'b0;
    tick(4);
  endtask

  initial begin
    //          clr   en    target edges cnt act done
    vecs[0] = '{1'b0, 1'b1, 24'd3, 2, 24'd2, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 24'd3, 1, 24'd3, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 24'd3, 1, 24'd3, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 24'd0, 2, 24'd2, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 24'd0, 0, 24'd2, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 24'd0, 5, 24'd2, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 24'd0, 1, 24'd3, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 24'd2, 2, 24'd5, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 24'd7, 2, 24'd7, 1'b0, 1'b1};

    #3;
    check("reset_cnt", 32'(cnt), 0);
    check("reset_active", 32'(active), 0);
    check("reset_done", 32'(done), 0);
    check("reset_ovf", 32'(ovf), 0);
    check("reset_ack", 32'(ack), 0);
    tick(2);
    resetb = 1'b1;
    tick(2);

    // Enable-to-RUN latency: three clocks.
    target = 24'd3;
    en = 1'b1;
    tick(2);
    check("en_lat_early", 32'(active), 0);
    tick(1);
    check("en_lat_active", 32'(active), 1);

    for (int v = 0; v < 9; v++) begin
      if (vecs[v].do_clr) do_clear();
      en = vecs[v].en;
      target = vecs[v].target;
      tick(4);
      pulse(vecs[v].edges);
      tick(2);
      check($sformatf("vec%0d_cnt", v), 32'(cnt), 32'(vecs[v].exp_cnt));
      check($sformatf("vec%0d_active", v), 32'(active), 32'(vecs[v].exp_active));
      check($sformatf("vec%0d_done", v), 32'(done), 32'(vecs[v].exp_done));
    end

    // Clear vs same-cycle edge at count 7, and clear latency of four clocks.
    target = '0;
    en = 1'b1;
    do_clear();
    pulse(7);
    check("pre_clr_cnt", 32'(cnt), 7);
    clr = 1'b1;
    tick(3);
    check("clr_lat_cnt", 32'(cnt), 7);
    freq = 1'b1;
    tick(1);
    check("clr_drop_cnt", 32'(cnt), 0);
    check("clr_idle", 32'(active), 0);
    freq = 1'b0;
    tick(1);
    check("clr_after_cnt", 32'(cnt), 0);
    clr = 1'b0;
    tick(6);

    // Edge in the same cycle the synchronized enable drops: counted, then PAUSE.
    pulse(2);
    en = 1'b0;
    tick(2);
    freq = 1'b1;
    tick(1);
    freq = 1'b0;
    check("endrop_cnt", 32'(cnt), 3);
    check("endrop_pause", 32'(active), 0);
    tick(7);
    en = 1'b1;
    tick(4);

    // Snapshot handshake.
    do_clear();
    pulse(5);
    req = 1'b1;
    tick(2);
    check("snap_ack_early", 32'(ack), 0);
    tick(1);
    check("snap_ack", 32'(ack), 1);
    check("snap_cnt", 32'(snap_cnt), 5);
    pulse(2);
    check("snap_live_cnt", 32'(cnt), 7);
    check("snap_hold", 32'(snap_cnt), 5);

    // Asynchronous reset mid-RUN.
    do_clear();
    pulse(9);
    check("prerst_cnt", 32'(cnt), 9);
    resetb = 1'b0;
    #1;
    check("rst_cnt", 32'(cnt), 0);
    check("rst_active", 32'(active), 0);
    check("rst_snap_cnt", 32'(snap_cnt), 0);
    check("rst_ack", 32'(ack), 0);
    req = 1'b0;
    tick(1);
    resetb = 1'b1;
    tick(2);
    check("rst_resume_early", 32'(active), 0);
    tick(1);
    check("rst_resume_active", 32'(active), 1);
    pulse(1);
    check("rst_resume_cnt", 32'(cnt), 1);

    // Saturation on a 4-bit counter.
    en4 = 1'b1;
    tick(4);
    pulse4(15);
    check("sat15_cnt", 32'(cnt4), 15);
    check("sat15_ovf", 32'(ovf4), 0);
    pulse4(2);
    check("sat17_cnt", 32'(cnt4), 15);
    check("sat17_ovf", 32'(ovf4), 1);
    clr4 = 1'b1;
    tick(4);
    check("sat_clr_cnt", 32'(cnt4), 0);
    check("sat_clr_ovf", 32'(ovf4), 0);
    check("sat_clr_idle", 32'(active4), 0);
    clr4 = 1'b0;
    tick(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
